// File: rtl/parameters_pkg.sv
// Shared field parameters and arbiter types for the Fp adder sharing logic.
package parameters_pkg;

  localparam int unsigned DATA_WIDTH = 448;
  // p = 2^448 - 2^224 - 1: all ones except bit 224
  localparam logic [DATA_WIDTH-1:0] MODULUS = {{223{1'b1}}, 1'b0, {224{1'b1}}};

  localparam int unsigned ARB_NUM_REQ = 4;
  localparam int unsigned ARB_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first valid requester at or after the pointer, wrapping.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] i_rr_ptr,
  output logic [$clog2(NUM_REQ)-1:0] o_grant,
  output logic                       o_any_valid
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = IDX_W'((int'(i_rr_ptr) + k) % NUM_REQ);
      if (!w_found && i_req_valid[w_idx]) begin
        w_found = 1'b1;
        o_grant = w_idx;
      end
    end
  end

  assign o_any_valid = |i_req_valid;

endmodule

// File: rtl/add_arbiter.sv
// Round-robin scheduler sharing one Fp adder between NUM_REQ requesters; one op outstanding.
module add_arbiter
  import parameters_pkg::*;
#(
  parameter int unsigned NUM_REQ = ARB_NUM_REQ,
  parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            resp_valid,
  input  logic [NUM_REQ-1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_sum,
  output logic                          add_start,
  output logic [DATA_WIDTH-1:0]         add_a,
  output logic [DATA_WIDTH-1:0]         add_b,
  input  logic [DATA_WIDTH-1:0]         add_sum,
  input  logic                          add_done,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t            r_state,       w_state_d;
  logic [IDX_W-1:0]      r_rr_ptr,      w_rr_ptr_d;
  logic [IDX_W-1:0]      r_grant,       w_grant_d;
  logic [DATA_WIDTH-1:0] r_add_a,       w_add_a_d;
  logic [DATA_WIDTH-1:0] r_add_b,       w_add_b_d;
  logic [DATA_WIDTH-1:0] r_resp_sum,    w_resp_sum_d;
  logic [CNT_W-1:0]      r_wait_cnt,    w_wait_cnt_d;
  logic                  r_timeout_err, w_timeout_err_d;

  logic [IDX_W-1:0]      w_pick;
  logic                  w_any_valid;
  logic                  w_accept;

  rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_picker (
    .i_req_valid(req_valid),
    .i_rr_ptr   (r_rr_ptr),
    .o_grant    (w_pick),
    .o_any_valid(w_any_valid)
  );

  always_comb begin
    w_state_d       = r_state;
    w_rr_ptr_d      = r_rr_ptr;
    w_grant_d       = r_grant;
    w_add_a_d       = r_add_a;
    w_add_b_d       = r_add_b;
    w_resp_sum_d    = r_resp_sum;
    w_wait_cnt_d    = r_wait_cnt;
    w_timeout_err_d = r_timeout_err;
    w_accept        = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_any_valid) begin
          w_accept  = 1'b1;
          w_grant_d = w_pick;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick == IDX_W'(i)) begin
              w_add_a_d = req_a[i*DATA_WIDTH +: DATA_WIDTH];
              w_add_b_d = req_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          w_state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        // add_done is not looked at here: it may still be high from the previous op
        w_wait_cnt_d = '0;
        w_state_d    = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (add_done) begin
          w_resp_sum_d = add_sum;
          w_state_d    = ARB_RESP;
        end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_timeout_err_d = 1'b1;
          w_resp_sum_d    = '0;
          w_state_d       = ARB_RESP;
        end else begin
          w_wait_cnt_d = r_wait_cnt + 1'b1;
        end
      end
      ARB_RESP: begin
        if (resp_ready[r_grant]) begin
          w_rr_ptr_d = (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
          w_state_d  = ARB_IDLE;
        end
      end
      default: w_state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ARB_IDLE;
      r_rr_ptr      <= '0;
      r_grant       <= '0;
      r_add_a       <= '0;
      r_add_b       <= '0;
      r_resp_sum    <= '0;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_rr_ptr      <= w_rr_ptr_d;
      r_grant       <= w_grant_d;
      r_add_a       <= w_add_a_d;
      r_add_b       <= w_add_b_d;
      r_resp_sum    <= w_resp_sum_d;
      r_wait_cnt    <= w_wait_cnt_d;
      r_timeout_err <= w_timeout_err_d;
    end
  end

  // req_ready is decoded from live inputs, so force it low while reset is held
  assign req_ready   = (w_accept && !rst) ? (NUM_REQ'(1) << w_pick) : '0;
  assign resp_valid  = (r_state == ARB_RESP) ? (NUM_REQ'(1) << r_grant) : '0;
  assign add_start   = (r_state == ARB_ISSUE);
  assign busy        = (r_state != ARB_IDLE);
  assign add_a       = r_add_a;
  assign add_b       = r_add_b;
  assign resp_sum    = r_resp_sum;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_add_arbiter.sv
// Randomised scoreboard bench for add_arbiter with a behavioural stub adder.
module tb_add_arbiter;
  import parameters_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned TO = 15;
  localparam int unsigned DW = DATA_WIDTH;
  localparam logic [DW-1:0] P = MODULUS;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [N*DW-1:0] req_a, req_b;
  logic [DW-1:0]   resp_sum, add_a, add_b, add_sum;
  logic            add_start, add_done, busy, timeout_err;

  add_arbiter #(
    .NUM_REQ(N),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .add_start  (add_start),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sum    (add_sum),
    .add_done   (add_done),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] rand_fe();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    if (v >= P) v = v - P;
    return v;
  endfunction

  // Reference arbitration: first valid index at/after the pointer, wrapping modulo N
  function automatic logic [IW-1:0] exp_grant(input logic [N-1:0] v, input logic [IW-1:0] ptr);
    logic [IW-1:0] idx;
    idx = ptr;
    for (int k = 0; k < N; k++) begin
      if (v[idx]) return idx;
      idx = idx + 1'b1;
    end
    return ptr;
  endfunction

  // Stub adder: done rises two edges after the start edge unless dead
  bit dead = 1'b0;
  bit rand_lat = 1'b0;
  int stub_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      add_done <= 1'b0;
      add_sum  <= '0;
      stub_cnt <= 0;
    end else if (add_start) begin
      add_done <= 1'b0;
      add_sum  <= mod_add(add_a, add_b);
      stub_cnt <= rand_lat ? int'($urandom_range(1, 5)) : 2;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1 && !dead) add_done <= 1'b1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and monitor
  logic [IW-1:0] sb_idx[$];
  logic [DW-1:0] sb_sum[$];
  logic [IW-1:0] glog[$];
  logic [IW-1:0] m_ptr = '0;
  logic [IW-1:0] mg;
  logic          prev_rv = 1'b0;
  int resp_cnt = 0, acc_cnt = 0, start_cnt = 0, acc_cyc = 0, resp_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      sb_idx.delete();
      sb_sum.delete();
      m_ptr   = '0;
      prev_rv = 1'b0;
    end else begin
      if (add_start) start_cnt++;
      chk("req_ready onehot0", DW'($onehot0(req_ready)), 1);
      chk("resp_valid onehot0", DW'($onehot0(resp_valid)), 1);
      if (req_ready != 0) begin
        mg = exp_grant(req_valid, m_ptr);
        chk("grant", req_ready, DW'(N'(1) << mg));
        chk("one outstanding", sb_idx.size(), 0);
        sb_idx.push_back(mg);
        sb_sum.push_back(dead ? '0 : mod_add(req_a[mg*DW +: DW], req_b[mg*DW +: DW]));
        for (int i = 0; i < N; i++) if (req_ready[i]) glog.push_back(IW'(i));
        acc_cyc = cyc;
        acc_cnt++;
      end
      if (resp_valid != 0 && !prev_rv) resp_cyc = cyc;
      prev_rv = |resp_valid;
      for (int i = 0; i < N; i++) begin
        if (resp_valid[i] && resp_ready[i]) begin
          if (sb_idx.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected response idx=%0d required=none", i);
          end else begin
            chk("resp idx", i, sb_idx[0]);
            chk("resp sum", resp_sum, sb_sum[0]);
            m_ptr = sb_idx[0] + 1'b1;
            void'(sb_idx.pop_front());
            void'(sb_sum.pop_front());
            resp_cnt++;
          end
        end
      end
    end
  end

  // Stimulus
  logic [DW-1:0] op_a[N], op_b[N];
  logic [N-1:0]  pend = '0;
  bit hold_valid = 1'b0;
  bit rand_on = 1'b0;

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    op_a[i] = a;
    op_b[i] = b;
    pend[i] = 1'b1;
  endtask

  task automatic step();
    if (rand_on) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) set_req(i, rand_fe(), rand_fe());
      end
      resp_ready = N'($urandom);
    end
    req_valid = pend;
    for (int i = 0; i < N; i++) begin
      req_a[i*DW +: DW] = op_a[i];
      req_b[i*DW +: DW] = op_b[i];
    end
    @(negedge clk);
    if (!hold_valid) pend = pend & ~req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((pend != 0 || busy || sb_idx.size() != 0) && n < 200) begin
      step();
      n++;
    end
    chk({name, " drain in bound"}, DW'(n < 200), 1);
  endtask

  task automatic chk_zero(input string t);
    chk({t, " req_ready"}, req_ready, 0);
    chk({t, " resp_valid"}, resp_valid, 0);
    chk({t, " resp_sum"}, resp_sum, 0);
    chk({t, " add_start"}, add_start, 0);
    chk({t, " add_a"}, add_a, 0);
    chk({t, " add_b"}, add_b, 0);
    chk({t, " busy"}, busy, 0);
    chk({t, " timeout_err"}, timeout_err, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, s0, r0, a0;
    logic [DW-1:0] ea;
    int exp2[5] = '{0, 1, 2, 3, 0};
    int exp3[3] = '{2, 3, 1};

    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // Single request, wrap of p-1 + 2
    resp_ready = '1;
    s0 = start_cnt;
    set_req(0, P - 1, 2);
    drain("t1");
    chk("t1 latency", resp_cyc - acc_cyc, 5);
    chk("t1 starts", start_cnt - s0, 1);
    chk("t1 sum", resp_sum, 1);

    // All four requesting continuously
    pulse_reset();
    glog.delete();
    hold_valid = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 5, 7);
    r0 = resp_cnt;
    n = 0;
    while (resp_cnt - r0 < 5 && n < 100) begin
      step();
      n++;
    end
    pend = '0;
    hold_valid = 1'b0;
    drain("t2");
    chk("t2 responses", resp_cnt - r0, 5);
    for (int k = 0; k < 5; k++) chk("t2 grant order", glog[k], exp2[k]);
    chk("t2 sum", resp_sum, 12);

    // Pointer at 3 with req1 and req3 pending
    glog.delete();
    set_req(2, rand_fe(), rand_fe());
    drain("t3a");
    set_req(1, rand_fe(), rand_fe());
    set_req(3, rand_fe(), rand_fe());
    drain("t3b");
    for (int k = 0; k < 3; k++) chk("t3 grant order", glog[k], exp3[k]);

    // Response backpressure
    resp_ready = '0;
    set_req(0, rand_fe(), rand_fe());
    ea = mod_add(op_a[0], op_b[0]);
    n = 0;
    while (resp_valid[0] !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("t4 resp reached", DW'(n < 50), 1);
    set_req(1, rand_fe(), rand_fe());
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t4 resp_valid held", resp_valid, 1);
      chk("t4 resp_sum stable", resp_sum, ea);
      chk("t4 no req_ready", req_ready, 0);
      chk("t4 busy", busy, 1);
    end
    resp_ready = '1;
    step();
    chk("t4 idle after release", busy, 0);
    chk("t4 next grant", req_ready, 4'b0010);
    drain("t4");

    // Adder never completes
    dead = 1'b1;
    set_req(2, rand_fe(), rand_fe());
    drain("t5a");
    chk("t5 timeout latency", resp_cyc - acc_cyc, TO + 2);
    chk("t5 timeout_err", timeout_err, 1);
    chk("t5 sum zero", resp_sum, 0);
    dead = 1'b0;
    set_req(3, rand_fe(), rand_fe());
    drain("t5b");
    chk("t5 timeout_err sticky", timeout_err, 1);

    // Reset while waiting on the adder
    a0 = acc_cnt;
    set_req(0, rand_fe(), rand_fe());
    n = 0;
    while (acc_cnt == a0 && n < 50) begin
      step();
      n++;
    end
    step();
    chk("t6 busy in wait", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk_zero("t6 async");
    pend = '0;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    glog.delete();
    set_req(2, P - 1, P - 1);
    drain("t6");
    chk("t6 grant", glog[0], 2);
    chk("t6 sum", resp_sum, P - 2);

    // Random traffic with random backpressure and adder latency
    rand_lat = 1'b1;
    rand_on = 1'b1;
    a0 = acc_cnt;
    r0 = resp_cnt;
    repeat (800) step();
    rand_on = 1'b0;
    resp_ready = '1;
    drain("random");
    chk("random balance", resp_cnt - r0, acc_cnt - a0);
    chk("random activity", DW'(resp_cnt - r0 > 20), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
